pixel_delay_line: RTL and testbench

Parametrised, programmable-depth delay line for the pixel pipeline. It carries NCH colour channels of DW bits plus CW control bits (sync/blanking) through a runtime-selectable delay of 1..MAX_DELAY enabled cycles. Its job is to keep the raw RGB and control signals aligned with the YUV generation path when that latency changes. It adds per-stage valid tracking, a clock-enable stall, and a flushing delay reload.

---
 rtl/pixel_delay_line.sv | 86 ++++++++
 tb/tb_pixel_delay_line.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_delay_line.sv
// Programmable-depth delay line for pixel, control and valid, keeping raw RGB
// aligned with the YUV path. Supports stall via en and a flushing delay reload.
module pixel_delay_line #(
    parameter int DW        = 8,
    parameter int NCH       = 3,
    parameter int CW        = 3,
    parameter int MAX_DELAY = 8,
    parameter int DEF_DELAY = 4,
    parameter int DLW       = $clog2(MAX_DELAY + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NCH*DW-1:0]   in_pix,
    input  logic [CW-1:0]       in_c,
    input  logic                in_valid,
    input  logic                dly_load,
    input  logic [DLW-1:0]      dly_req,
    output logic [NCH*DW-1:0]   out_pix,
    output logic [CW-1:0]       out_c,
    output logic                out_valid,
    output logic                primed,
    output logic [DLW-1:0]      dly_cur
);

    logic [MAX_DELAY-1:0][NCH*DW-1:0] r_pix;
    logic [MAX_DELAY-1:0][CW-1:0]     r_c;
    logic [MAX_DELAY-1:0]             r_vld;
    logic [DLW-1:0]                   r_dly;
    logic [DLW-1:0]                   r_cnt;
    logic [DLW-1:0]                   w_req;

    // Requested delay is forced into 1..MAX_DELAY before it is adopted
    always_comb begin
        w_req = dly_req;
        if (dly_req == '0)
            w_req = DLW'(1);
        else if (dly_req > DLW'(MAX_DELAY))
            w_req = DLW'(MAX_DELAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix <= '0;
            r_c   <= '0;
            r_vld <= '0;
            r_cnt <= '0;
            r_dly <= DLW'(DEF_DELAY);
        end else if (dly_load) begin
            r_pix <= '0;
            r_c   <= '0;
            r_vld <= '0;
            r_cnt <= '0;
            r_dly <= w_req;
        end else if (en) begin
            for (int k = MAX_DELAY - 1; k >= 1; k--) begin
                r_pix[k] <= r_pix[k-1];
                r_c[k]   <= r_c[k-1];
                r_vld[k] <= r_vld[k-1];
            end
            r_pix[0] <= in_pix;
            r_c[0]   <= in_c;
            r_vld[0] <= in_valid;
            if (r_cnt != r_dly)
                r_cnt <= r_cnt + DLW'(1);
        end
    end

    // Tap stage dly_cur-1; r_dly is always in 1..MAX_DELAY so one arm matches
    always_comb begin
        out_pix   = '0;
        out_c     = '0;
        out_valid = 1'b0;
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (r_dly == DLW'(k + 1)) begin
                out_pix   = r_pix[k];
                out_c     = r_c[k];
                out_valid = r_vld[k];
            end
        end
    end

    assign primed  = (r_cnt == r_dly);
    assign dly_cur = r_dly;

endmodule

// File: tb/tb_pixel_delay_line.sv
// Directed bench for pixel_delay_line: reset, delay extremes, stall, reload,
// valid/control alignment and rst/load priority.
module tb_pixel_delay_line;

    localparam int DW = 8, NCH = 3, CW = 3, MAX_DELAY = 8, DEF_DELAY = 4;
    localparam int DLW = $clog2(MAX_DELAY + 1);

    logic               clk = 1'b0;
    logic               rst, en, in_valid, dly_load;
    logic [NCH*DW-1:0]  in_pix;
    logic [CW-1:0]      in_c;
    logic [DLW-1:0]     dly_req;
    logic [NCH*DW-1:0]  out_pix;
    logic [CW-1:0]      out_c;
    logic               out_valid, primed;
    logic [DLW-1:0]     dly_cur;

    int n_checks = 0;
    int n_errs   = 0;

    pixel_delay_line #(
        .DW(DW), .NCH(NCH), .CW(CW), .MAX_DELAY(MAX_DELAY), .DEF_DELAY(DEF_DELAY)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .in_pix(in_pix), .in_c(in_c),
        .in_valid(in_valid), .dly_load(dly_load), .dly_req(dly_req),
        .out_pix(out_pix), .out_c(out_c), .out_valid(out_valid),
        .primed(primed), .dly_cur(dly_cur)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int d);
        dly_load = 1'b1;
        dly_req  = DLW'(d);
        step();
        dly_load = 1'b0;
    endtask

    int vpat [5] = '{1, 0, 1, 1, 0};

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; dly_load = 1'b0;
        in_pix = '0; in_c = '0; dly_req = '0;

        // Reset state
        step(); step();
        chk("rst_pix", out_pix, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_primed", primed, 0);
        chk("rst_dly", dly_cur, 4);

        // Default delay 4 with ramp
        rst = 1'b0; en = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            in_pix = 24'(i);
            step();
            if (i < 4) begin
                chk($sformatf("def_pix%0d", i), out_pix, 0);
                chk($sformatf("def_primed%0d", i), primed, 0);
            end else begin
                chk($sformatf("def_pix%0d", i), out_pix, i - 3);
                chk($sformatf("def_primed%0d", i), primed, 1);
            end
        end
        chk("def_valid", out_valid, 1);
        chk("def_dly", dly_cur, 4);

        // Delay 1; load-cycle input is discarded
        in_pix = 24'd99;
        load(1);
        chk("d1_dly", dly_cur, 1);
        chk("d1_flush_pix", out_pix, 0);
        chk("d1_flush_valid", out_valid, 0);
        chk("d1_flush_primed", primed, 0);
        in_pix = 24'd10; step();
        chk("d1_pix10", out_pix, 10);
        chk("d1_primed", primed, 1);
        in_pix = 24'd11; step();
        chk("d1_pix11", out_pix, 11);

        // dly_req=0 clamps to 1
        load(0);
        chk("d0_dly", dly_cur, 1);

        // dly_req=15 clamps to MAX_DELAY
        load(15);
        chk("d15_dly", dly_cur, 8);
        for (int k = 1; k <= 8; k++) begin
            in_pix = 24'(19 + k);
            step();
            if (k == 7) begin
                chk("d8_pix_k7", out_pix, 0);
                chk("d8_primed_k7", primed, 0);
            end
        end
        chk("d8_pix_k8", out_pix, 20);
        chk("d8_primed_k8", primed, 1);

        // Stall at delay 4
        load(4);
        for (int k = 0; k < 5; k++) begin
            in_pix = 24'(30 + k);
            step();
        end
        chk("st_pre", out_pix, 31);
        en = 1'b0; in_pix = 24'd77;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("st_hold%0d", k), out_pix, 31);
        end
        chk("st_primed_hold", primed, 1);
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_pix = 24'(35 + k);
            step();
            chk($sformatf("st_post%0d", k), out_pix, 32 + k);
        end

        // Load mid-stream to delay 2
        in_pix = 24'd50;
        load(2);
        chk("lm_pix", out_pix, 0);
        chk("lm_valid", out_valid, 0);
        chk("lm_primed", primed, 0);
        chk("lm_dly", dly_cur, 2);
        in_pix = 24'd51; step();
        chk("lm_pix_e1", out_pix, 0);
        in_pix = 24'd52; step();
        chk("lm_pix_e2", out_pix, 51);
        chk("lm_primed_e2", primed, 1);

        // Valid/control alignment at delay 3
        load(3);
        for (int j = 1; j <= 7; j++) begin
            if (j <= 5) begin
                in_pix   = 24'(59 + j);
                in_valid = vpat[j-1][0];
                in_c     = CW'(j - 1);
            end else begin
                in_pix = '0; in_valid = 1'b0; in_c = '0;
            end
            step();
            if (j >= 3) begin
                chk($sformatf("va_pix%0d", j), out_pix, 60 + j - 3);
                chk($sformatf("va_valid%0d", j), out_valid, vpat[j-3]);
                chk($sformatf("va_c%0d", j), out_c, j - 3);
            end
        end

        // rst beats dly_load
        rst = 1'b1; dly_load = 1'b1; dly_req = DLW'(2);
        step();
        rst = 1'b0; dly_load = 1'b0;
        chk("pr_dly", dly_cur, 4);
        chk("pr_pix", out_pix, 0);
        chk("pr_valid", out_valid, 0);
        chk("pr_primed", primed, 0);

        // dly_load flushes even while stalled
        in_pix = 24'd70; in_valid = 1'b1; en = 1'b1;
        step(); step();
        en = 1'b0;
        load(2);
        chk("ps_dly", dly_cur, 2);
        chk("ps_pix", out_pix, 0);
        chk("ps_valid", out_valid, 0);
        en = 1'b1; in_pix = 24'd80; step();
        chk("ps_flushed", out_pix, 0);
        in_pix = 24'd81; step();
        chk("ps_pix80", out_pix, 80);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
